// File: rtl/qick_sync_queue_if.sv
// Bus interface for qick_sync_queue.
// The master side drives push/pop requests, write data, thresholds, flush and error clear.
// The slave side (the queue) returns the head word, fill count, status flags and sticky errors.
interface qick_sync_queue_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 4
);
  logic          flush_i;
  logic          push_i;
  logic [DW-1:0] data_i;
  logic          pop_i;
  logic [DW-1:0] data_o;
  logic          empty_o;
  logic          full_o;
  logic [AW:0]   count_o;
  logic [AW:0]   afull_thr_i;
  logic [AW:0]   aempty_thr_i;
  logic          afull_o;
  logic          aempty_o;
  logic          ovf_o;
  logic          unf_o;
  logic          clr_err_i;

  modport master (
    output flush_i, push_i, data_i, pop_i, afull_thr_i, aempty_thr_i, clr_err_i,
    input  data_o, empty_o, full_o, count_o, afull_o, aempty_o, ovf_o, unf_o
  );

  modport slave (
    input  flush_i, push_i, data_i, pop_i, afull_thr_i, aempty_thr_i, clr_err_i,
    output data_o, empty_o, full_o, count_o, afull_o, aempty_o, ovf_o, unf_o
  );
endinterface

// File: rtl/qick_sync_queue.sv
// Register-array queue, FIFO or LIFO selected by MODE, all 2**AW entries usable.
// Ports: clk_i, rst_i (synchronous, active-high), q (qick_sync_queue_if.slave):
//   push/pop requests with first-word-fall-through data_o, fill count, full/empty,
//   programmable almost-full/almost-empty, sticky overflow/underflow flags.
module qick_sync_queue #(
  parameter int unsigned DW   = 16,
  parameter int unsigned AW   = 4,
  parameter string       MODE = "FIFO"
) (
  input logic             clk_i,
  input logic             rst_i,
  qick_sync_queue_if.slave q
);

  localparam int unsigned DEPTH   = 2 ** AW;
  localparam bit          IS_LIFO = (MODE == "LIFO");

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          empty_c, full_c;
  logic          acc_push_c, acc_pop_c;
  logic [AW-1:0] waddr_c, raddr_c;

  // Acceptance, addressing and next-state
  always_comb begin
    empty_c    = (count_q == '0);
    full_c     = (count_q == (AW+1)'(DEPTH));
    acc_pop_c  = q.pop_i & ~empty_c;
    // FIFO may push into a full queue whenever a pop is requested (a full queue always pops);
    // LIFO needs the pop to actually be accepted so the top slot is replaced.
    acc_push_c = IS_LIFO ? (q.push_i & (~full_c | acc_pop_c))
                         : (q.push_i & (~full_c | q.pop_i));
    count_d    = count_q + (AW+1)'(acc_push_c) - (AW+1)'(acc_pop_c);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    waddr_c    = wr_ptr_q;
    raddr_c    = rd_ptr_q;
    if (IS_LIFO) begin
      // Stack pointer is the count; simultaneous push/pop overwrites the top entry
      waddr_c = (acc_push_c & acc_pop_c) ? AW'(count_q - (AW+1)'(1)) : AW'(count_q);
      raddr_c = empty_c ? '0 : AW'(count_q - (AW+1)'(1));
    end else begin
      if (acc_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (acc_pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // A new error event in the same cycle as clr_err_i keeps the flag set
    ovf_d = (ovf_q & ~q.clr_err_i) | (q.push_i & ~acc_push_c);
    unf_d = (unf_q & ~q.clr_err_i) | (q.pop_i & empty_c);
  end

  // State and storage registers; flush leaves the array contents alone
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (q.flush_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      if (acc_push_c) mem_q[waddr_c] <= q.data_i;
    end
  end

  assign q.data_o   = mem_q[raddr_c];
  assign q.empty_o  = empty_c;
  assign q.full_o   = full_c;
  assign q.count_o  = count_q;
  assign q.afull_o  = (count_q >= q.afull_thr_i);
  assign q.aempty_o = (count_q <= q.aempty_thr_i);
  assign q.ovf_o    = ovf_q;
  assign q.unf_o    = unf_q;

endmodule
